pipe_mdu_ctrl: RTL and testbench
================================

PIPE_MDU_CTRL -- requirements
Module: pipe_mdu_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning iterations per multiply/divide operation.
REQ-002 SHALL have port clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 SHALL have port clrn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port estart  in  1  EXE-stage instruction is MULT/MULTU/DIV/DIVU.
REQ-005 SHALL have port eop  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port ea, eb  in  32 each  EXE operands (rs, rt).
REQ-007 SHALL have port ewhi, ewlo  in  1 each  MTHI/MTLO in EXE; data taken from ea.
REQ-008 SHALL have port eflush  in  1  abort the in-flight operation (exception/redirect).
REQ-009 SHALL have port stall  out  1  freeze PC, IF/ID and ID/EXE registers and inject a bubble into EXE/MEM.
REQ-010 SHALL have port done  out  1  one-cycle pulse when HI/LO are updated by an operation.
REQ-011 SHALL have ports hi, lo  out  32 each  architectural HI/LO registers (MFHI/MFLO source).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE & estart & !eflush: SHALL latch eop, the operand magnitudes (two's-complement absolute values for signed ops) and the result-sign flags; SHALL clear the iteration counter; next state BUSY.
REQ-014 stall SHALL be combinational: (IDLE & estart & !eflush) | BUSY.
REQ-015 BUSY SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; counter increments; after ITER steps next state DONE.
REQ-016 DONE SHALL write hi/lo with sign correction: multiply {hi,lo}=64-bit product; divide lo=quotient, hi=remainder; remainder takes the dividend's sign. DONE SHALL pulse done, deassert stall and go to IDLE. estart SHALL be ignored in DONE.
REQ-017 Latency with ITER=32: estart accepted in cycle 0; stall high in cycles 0..32; DONE in cycle 33; new hi/lo visible from cycle 34. A back-to-back operation SHALL be accepted in cycle 34.
REQ-018 Divide by zero SHALL complete with normal latency: lo=32'hFFFFFFFF, hi=ea, with no sign correction.
REQ-019 Signed 0x80000000 / -1 SHALL give lo=0x80000000, hi=0.
REQ-020 eflush in BUSY or DONE SHALL force IDLE next cycle with hi/lo unchanged and no done pulse; stall SHALL drop in the cycle after eflush.
REQ-021 In IDLE without estart, ewhi SHALL load hi<=ea and ewlo SHALL load lo<=ea; both are ignored in BUSY/DONE and when eflush=1. estart has priority.
REQ-022 Operand inputs SHALL be sampled only at acceptance; later changes on ea/eb SHALL NOT affect the result.

Reset
REQ-023 clrn=0 at a rising edge SHALL set state=IDLE, counter=0, hi=0, lo=0, and clear all operand and accumulator registers.
REQ-024 During reset, stall=0 and done=0; reset mid-BUSY SHALL discard the operation.

Structure
REQ-025 Shared package mdu_pkg SHALL hold the eop encodings, the state encodings and the ITER default.
REQ-026 The iterative datapath SHALL be the sub-module mdu_core (accumulator, shift registers, adder/subtractor, step enable). pipe_mdu_ctrl SHALL hold the FSM, counter, sign handling and HI/LO.

Verification
REQ-027 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 33 cycles; done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 DIVU 17 / 5 started; eflush at cycle 10 -> IDLE at cycle 11, stall=0 at cycle 11, hi/lo keep their prior values, no done pulse.
REQ-031 MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. Back-to-back MULTU 2x3 then MULTU 4x5 -> second accepted in cycle 34; final lo=20.
REQ-032 clrn=0 at cycle 15 of BUSY -> IDLE, hi=lo=0, stall=0; a following MULTU 6x7 gives lo=42.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, controller states and the default step count.
package mdu_pkg;
  localparam int ITER_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mdu_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide, one step per cycle.
// acc holds the product high half / remainder, sreg the product low half / quotient.
module mdu_core (
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] ld_s,
  input  logic [31:0] ld_b,
  output logic [31:0] acc,
  output logic [31:0] sreg
);
  logic [31:0] breg;
  logic [32:0] sum, shf, diff;

  always_comb begin
    sum  = {1'b0, acc} + (sreg[0] ? {1'b0, breg} : 33'd0);
    shf  = {acc, sreg[31]};
    diff = shf - {1'b0, breg};
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      acc  <= '0;
      sreg <= '0;
      breg <= '0;
    end else if (load) begin
      acc  <= '0;
      sreg <= ld_s;
      breg <= ld_b;
    end else if (step) begin
      if (is_div) begin
        // The partial remainder stays below the divisor, so a set bit 32 of diff means borrow.
        if (!diff[32]) begin
          acc  <= diff[31:0];
          sreg <= {sreg[30:0], 1'b1};
        end else begin
          acc  <= shf[31:0];
          sreg <= {sreg[30:0], 1'b0};
        end
      end else begin
        acc  <= sum[32:1];
        sreg <= {sum[0], sreg[31:1]};
      end
    end
  end
endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Pipeline-side MDU controller: accepts MULT/DIV from EXE, stalls the pipe while
// the core iterates, then writes sign-corrected results into HI/LO.
module pipe_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        ewhi,
  input  logic        ewlo,
  input  logic        eflush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2(ITER + 1);

  state_e          state, state_n;
  op_e             op;
  logic            pneg, rneg;
  logic [CW-1:0]   cnt;
  logic            accept, sgn, a_neg, b_neg, e_div;
  logic [31:0]     a_mag, b_mag, acc, sreg;
  logic [63:0]     prod;

  always_comb begin
    accept = (state == S_IDLE) && estart && !eflush;
    e_div  = eop[1];
    sgn    = !eop[0];
    a_neg  = sgn && ea[31];
    b_neg  = sgn && eb[31];
    a_mag  = a_neg ? -ea : ea;
    b_mag  = b_neg ? -eb : eb;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = S_BUSY;
      S_BUSY: if (eflush) state_n = S_IDLE;
              else if (cnt == CW'(ITER - 1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign stall = clrn && (accept || (state == S_BUSY));
  assign done  = clrn && (state == S_DONE) && !eflush;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= OP_MULT;
      pneg  <= 1'b0;
      rneg  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt  <= '0;
        op   <= op_e'(eop);
        // A zero divisor reports an all-ones quotient, so it must never be negated.
        pneg <= e_div ? ((a_neg ^ b_neg) && (eb != 32'd0)) : (a_neg ^ b_neg);
        rneg <= a_neg;
      end else if (state == S_BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  mdu_core u_core (
    .clk    (clk),
    .clrn   (clrn),
    .load   (accept),
    .step   (state == S_BUSY),
    .is_div (op[1]),
    .ld_s   (e_div ? a_mag : b_mag),
    .ld_b   (e_div ? b_mag : a_mag),
    .acc    (acc),
    .sreg   (sreg)
  );

  assign prod = pneg ? -{acc, sreg} : {acc, sreg};

  always_ff @(posedge clk) begin
    if (!clrn) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (op[1]) begin
        lo <= pneg ? -sreg : sreg;
        hi <= rneg ? -acc : acc;
      end else begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end
    end else if ((state == S_IDLE) && !estart && !eflush) begin
      if (ewhi) hi <= ea;
      if (ewlo) lo <= ea;
    end
  end
endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Self-checking bench for pipe_mdu_ctrl: directed vectors, multi-cycle corner
// sequences and random operations checked against an arithmetic reference.
module tb_pipe_mdu_ctrl;
  logic        clk = 1'b0;
  logic        clrn, estart, ewhi, ewlo, eflush;
  logic [1:0]  eop;
  logic [31:0] ea, eb;
  logic        stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  pipe_mdu_ctrl #(.ITER(32)) dut (
    .clk(clk), .clrn(clrn), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
    .ewhi(ewhi), .ewlo(ewlo), .eflush(eflush), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
        else begin q = longint'({32'd0, a}) / longint'({32'd0, b}); r = longint'({32'd0, a}) % longint'({32'd0, b}); end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Enters in cycle 0 (just after a rising edge) and returns in the cycle the result becomes visible.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int stall_n, done_c;
    stall_n = 0;
    done_c  = -1;
    estart = 1'b1; eop = op; ea = a; eb = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (done && done_c < 0) done_c = c;
      @(posedge clk); #1;
      if (c == 0) begin estart = 1'b0; ea = $urandom; eb = $urandom; end
      if (done_c >= 0) break;
    end
    chk({nm, ".stall_cycles"}, 64'(stall_n), 64'd33);
    chk({nm, ".done_cycle"}, 64'(done_c), 64'd33);
    chk({nm, ".hilo"}, {hi, lo}, {ehi, elo});
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1] = '{2'b00, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg7x3"};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7d2"};
    vecs[3] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0"};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
    vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_minsq"};
    vecs[7] = '{2'b11, 32'd17,        32'd5,         32'd2,         32'd3,         "divu_17d5"};

    clrn = 1'b0; estart = 1'b1; eop = 2'b01; ea = 32'd9; eb = 32'd9;
    ewhi = 1'b0; ewlo = 1'b0; eflush = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    @(posedge clk); #1;
    estart = 1'b0; clrn = 1'b1;
    chk("rst.hilo", {hi, lo}, 64'd0);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].nm);

    // MTLO / MTHI in IDLE, and a move suppressed by eflush
    ewlo = 1'b1; ea = 32'h1234;
    @(posedge clk); #1; ewlo = 1'b0;
    chk("mtlo", 64'(lo), 64'h1234);
    ewhi = 1'b1; ea = 32'hAAAA_5555;
    @(posedge clk); #1; ewhi = 1'b0;
    chk("mthi", 64'(hi), 64'hAAAA_5555);
    ewhi = 1'b1; eflush = 1'b1; ea = 32'hDEAD_BEEF;
    @(posedge clk); #1; ewhi = 1'b0; eflush = 1'b0;
    chk("mthi_flushed", 64'(hi), 64'hAAAA_5555);

    // back-to-back: the second op starts in the cycle the first result appears
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, "b2b_first");
    run_op(2'b01, 32'd4, 32'd5, 32'd0, 32'd20, "b2b_second");

    // flush during BUSY
    ewhi = 1'b1; ewlo = 1'b1; ea = 32'h0BAD_F00D;
    @(posedge clk); #1; ewhi = 1'b0; ewlo = 1'b0;
    estart = 1'b1; eop = 2'b11; ea = 32'd17; eb = 32'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) estart = 1'b0;
    end
    eflush = 1'b1;
    @(negedge clk);
    chk("flush.done_c10", 64'(done), 64'd0);
    @(posedge clk); #1; eflush = 1'b0;
    @(negedge clk);
    chk("flush.stall_c11", 64'(stall), 64'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("flush.no_done", 64'(seen), 64'd0);
    chk("flush.hilo", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});
    @(posedge clk); #1;

    // reset in the middle of BUSY
    estart = 1'b1; eop = 2'b01; ea = 32'hFFFF; eb = 32'hFFFF;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (c == 0) estart = 1'b0;
    end
    clrn = 1'b0;
    @(negedge clk);
    chk("midrst.stall", 64'(stall), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    @(posedge clk); #1; clrn = 1'b1;
    chk("midrst.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    chk("midrst.stall_after", 64'(stall), 64'd0);
    @(posedge clk); #1;
    run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "after_rst");

    // random operations against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000)));
      if ($urandom_range(0, 1) == 1) ra = 32'($signed(ra) >>> $urandom_range(0, 28));
      e = ref_mdu(rop, ra, rb);
      run_op(rop, ra, rb, e[63:32], e[31:0], $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
